// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute stage and the multiply/divide
// sequencer.
//
//   req_valid / req_ready   request handshake (pipeline -> sequencer)
//   req_op                  0 = MUL, 1 = DIVU
//   req_a / req_b           multiplicand/dividend, multiplier/divisor
//   resp_valid / resp_ready response handshake (sequencer -> pipeline)
//   resp_lo / resp_hi       product[31:0]/quotient, product[63:32]/remainder
//   resp_divz               divide-by-zero flag
//
// master = pipeline side, slave = sequencer side.
interface alu_muldiv_seq_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_lo;
  logic [DATA_W-1:0] resp_hi;
  logic              resp_divz;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_lo, resp_hi, resp_divz
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_lo, resp_hi, resp_divz
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply / divide sequencer.
//
// Computes a 32x32 -> 64 unsigned product by shift-add, or an unsigned
// quotient/remainder by restoring division, one bit per clock. It owns no
// adder: every add/subtract is issued to the shared combinational ALU through
// alu_ct/alu_src1/alu_src2, and alu_res is consumed in the same cycle.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-low reset
//   bus       request/response handshake bundle (slave side)
//   alu_ct    ALU control code (add or subtract)
//   alu_src1  ALU operand 1
//   alu_src2  ALU operand 2
//   alu_res   ALU result, combinational from the three outputs above
module alu_muldiv_seq #(
  parameter int              DATA_W   = 32,
  parameter logic [3:0]      ALU_ADD  = 4'b0010,
  parameter logic [3:0]      ALU_SUB  = 4'b0110,
  parameter logic [DATA_W-1:0] DIVZ_QUO = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  alu_muldiv_seq_if.slave   bus,
  output logic [3:0]        alu_ct,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_res
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Working registers shared by both algorithms:
  //   MUL: hi_q = partial product high half, lo_q = multiplier/product low half
  //   DIV: hi_q = partial remainder,         lo_q = dividend/quotient
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] b_q;

  // Result registers are separate from the working registers so the last
  // response stays visible while a new operation is running.
  logic [DATA_W-1:0] resp_lo_q;
  logic [DATA_W-1:0] resp_hi_q;
  logic              resp_divz_q;

  logic              req_ready;
  logic              resp_valid;
  logic              last_iter;
  logic              accept;
  logic              divz_req;

  // One-iteration results computed from the ALU readback.
  logic [DATA_W-1:0] iter_hi;
  logic [DATA_W-1:0] iter_lo;
  logic              mul_carry;
  logic              div_ge;
  logic              sh_top;
  logic [DATA_W-1:0] sh_lo;

  assign last_iter = (cnt == CNT_LAST);
  assign accept    = req_ready & bus.req_valid;
  assign divz_req  = bus.req_op & (bus.req_b == '0);

  // {rem, quo[msb]}: the 33-bit shifted partial remainder, split into its
  // overflow bit and the 32 bits the ALU can see.
  assign sh_top = hi_q[DATA_W-1];
  assign sh_lo  = {hi_q[DATA_W-2:0], lo_q[DATA_W-1]};

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_lo    = resp_lo_q;
  assign bus.resp_hi    = resp_hi_q;
  assign bus.resp_divz  = resp_divz_q;

  // ---- state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next state, handshake and ALU drive ----
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    alu_ct     = ALU_ADD;
    alu_src1   = '0;
    alu_src2   = '0;
    mul_carry  = 1'b0;
    div_ge     = 1'b0;
    iter_hi    = hi_q;
    iter_lo    = lo_q;

    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          if (!bus.req_op) begin
            state_nxt = S_MUL;
          end else if (divz_req) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_DIV;
          end
        end
      end

      S_MUL: begin
        alu_ct   = ALU_ADD;
        alu_src1 = hi_q;
        alu_src2 = lo_q[0] ? b_q : '0;
        // A 32-bit add wrapped iff the sum is smaller than an addend.
        mul_carry = (alu_res < hi_q);
        // {carry, sum, lo} shifted right by one bit.
        iter_hi = {mul_carry, alu_res[DATA_W-1:1]};
        iter_lo = {alu_res[0], lo_q[DATA_W-1:1]};
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end

      S_DIV: begin
        alu_ct   = ALU_SUB;
        alu_src1 = sh_lo;
        alu_src2 = b_q;
        // With the 33rd bit set the shifted remainder exceeds any 32-bit
        // divisor, and the 32-bit difference is still exact.
        div_ge  = sh_top | (sh_lo >= b_q);
        iter_hi = div_ge ? alu_res : sh_lo;
        iter_lo = {lo_q[DATA_W-2:0], div_ge};
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- working and result registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      resp_lo_q   <= '0;
      resp_hi_q   <= '0;
      resp_divz_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            cnt  <= '0;
            hi_q <= '0;
            lo_q <= bus.req_a;
            b_q  <= bus.req_b;
            // Divide-by-zero is answered immediately without iterating.
            if (divz_req) begin
              resp_lo_q   <= DIVZ_QUO;
              resp_hi_q   <= bus.req_a;
              resp_divz_q <= 1'b1;
            end
          end
        end

        S_MUL, S_DIV: begin
          cnt  <= cnt + 1'b1;
          hi_q <= iter_hi;
          lo_q <= iter_lo;
          if (last_iter) begin
            resp_lo_q   <= iter_lo;
            resp_hi_q   <= iter_hi;
            resp_divz_q <= 1'b0;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  logic        clk;
  logic        rst;
  logic [3:0]  alu_ct;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_res;

  int nchk;
  int nfail;

  alu_muldiv_seq_if #(.DATA_W(32)) bus ();

  alu_muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_ct   (alu_ct),
    .alu_src1 (alu_src1),
    .alu_src2 (alu_src2),
    .alu_res  (alu_res)
  );

  // Stand-in for the execute-stage ALU: add or subtract.
  assign alu_res = (alu_ct == ALU_SUB) ? (alu_src1 - alu_src2) : (alu_src1 + alu_src2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_alu_ct"}, 64'(alu_ct), 64'(ALU_ADD));
    check({tag, "_alu_src1"}, 64'(alu_src1), 64'd0);
    check({tag, "_alu_src2"}, 64'(alu_src2), 64'd0);
  endtask

  // Issues one request and checks latency, result and handshake behaviour.
  // hold: cycles to keep resp_ready low after resp_valid rises.
  // poke: drive stray requests while the sequencer is busy or holding a result.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit poke);
    logic [63:0] prod;
    logic [31:0] exp_lo, exp_hi;
    logic        exp_divz;
    int          exp_lat;
    int          lat;

    // Reference results straight from unsigned arithmetic.
    if (!op) begin
      prod     = 64'(a) * 64'(b);
      exp_lo   = prod[31:0];
      exp_hi   = prod[63:32];
      exp_divz = 1'b0;
      exp_lat  = 32;
    end else if (b == 32'd0) begin
      exp_lo   = 32'hFFFFFFFF;
      exp_hi   = a;
      exp_divz = 1'b1;
      exp_lat  = 0;
    end else begin
      exp_lo   = a / b;
      exp_hi   = a % b;
      exp_divz = 1'b0;
      exp_lat  = 32;
    end

    check("ready_before_req", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;

    // lat = number of rising edges after the accepting edge before
    // resp_valid is seen.
    lat = 0;
    if (exp_lat != 0) begin
      check("alu_ct_busy", 64'(alu_ct), op ? 64'(ALU_SUB) : 64'(ALU_ADD));
      check("ready_busy", 64'(bus.req_ready), 64'd0);
    end
    while (!bus.resp_valid && lat < 40) begin
      if (poke) begin
        bus.req_valid = 1'b1;
        bus.req_op    = 1'($urandom);
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    bus.req_valid = 1'b0;

    check("latency", 64'(lat), 64'(exp_lat));
    check("resp_valid", 64'(bus.resp_valid), 64'd1);
    check("resp_lo", 64'(bus.resp_lo), 64'(exp_lo));
    check("resp_hi", 64'(bus.resp_hi), 64'(exp_hi));
    check("resp_divz", 64'(bus.resp_divz), 64'(exp_divz));
    check("ready_done", 64'(bus.req_ready), 64'd0);
    check("alu_done", {alu_src1, alu_src2}, 64'd0);
    check("alu_ct_done", 64'(alu_ct), 64'(ALU_ADD));

    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.req_valid = 1'b1;
        bus.req_a     = $urandom;
      end
      @(negedge clk);
      check("hold_valid", 64'(bus.resp_valid), 64'd1);
      check("hold_data", {bus.resp_hi, bus.resp_lo}, {exp_hi, exp_lo});
      check("hold_ready", 64'(bus.req_ready), 64'd0);
    end

    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check_idle_outputs("after_resp");
    check("kept_data", {bus.resp_hi, bus.resp_lo}, {exp_hi, exp_lo});
    check("kept_divz", 64'(bus.resp_divz), 64'(exp_divz));
  endtask

  initial begin
    logic        op;
    logic [31:0] a, b;

    nchk  = 0;
    nfail = 0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_resp", {bus.resp_hi, bus.resp_lo}, 64'd0);
    check("reset_divz", 64'(bus.resp_divz), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(1'b0, 32'd7, 32'd6, 0, 1'b0);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 0, 1'b0);
    run_op(1'b1, 32'hFFFFFFFF, 32'h80000001, 0, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 0, 1'b0);
    run_op(1'b0, 32'd3, 32'd5, 5, 1'b1);
    run_op(1'b1, 32'd9, 32'd0, 3, 1'b1);

    // Reset in the middle of a divide
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    bus.req_a     = 32'd1000;
    bus.req_b     = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("midop_reset");
    check("midop_resp", {bus.resp_hi, bus.resp_lo}, 64'd0);
    check("midop_divz", 64'(bus.resp_divz), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_no_resp", 64'(bus.resp_valid), 64'd0);
    run_op(1'b0, 32'd2, 32'd2, 0, 1'b0);

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      op = 1'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      run_op(op, a, b, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that performs 32x32 unsigned multiply (64-bit product) and unsigned divide (quotient and remainder).
- Reuses the existing combinational ALU for its adds and subtracts instead of instantiating a separate adder.
- Drives the ALU's control code and both operands directly. Reads back the ALU result in the same cycle.
- Sits beside the execute stage. The pipeline hands it requests through a valid/ready handshake and collects results through a second valid/ready handshake.

Parameters:
- ALU_ADD, 4'b0010, ALU control code for add.
- ALU_SUB, 4'b0110, ALU control code for subtract.
- DIVZ_QUO, 32'hFFFFFFFF, quotient returned on divide-by-zero.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  1  0 = MUL, 1 = DIVU.
- req_a  in  32  multiplicand / dividend.
- req_b  in  32  multiplier / divisor.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_lo  out  32  product[31:0] / quotient.
- resp_hi  out  32  product[63:32] / remainder.
- resp_divz  out  1  divide-by-zero flag.
- alu_ct  out  4  ALU control code.
- alu_src1  out  32  ALU operand 1.
- alu_src2  out  32  ALU operand 2.
- alu_res  in  32  ALU result, combinational from alu_ct/alu_src1/alu_src2.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, all internal registers cleared, iteration counter=0.
  - Outputs: req_ready=1, resp_valid=0, resp_lo=0, resp_hi=0, resp_divz=0, alu_ct=ALU_ADD, alu_src1=0, alu_src2=0.
  - Reset mid-operation discards the operation; no response is produced.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - req_ready=1; ALU outputs at their reset values.
  - On req_valid=1, latch req_a and req_b, clear cnt, and go to MUL (req_op=0) or DIV (req_op=1).
  - Divide with req_b==0 goes straight to DONE with resp_lo=DIVZ_QUO, resp_hi=req_a, resp_divz=1. resp_valid is high the cycle after acceptance.
- MUL, shift-add. Registers: hi=0, lo=req_a, b=req_b. One iteration per cycle:
  - alu_ct=ALU_ADD, alu_src1=hi, alu_src2 = lo[0] ? b : 0.
  - carry = (alu_res < alu_src1), unsigned.
  - Update {hi,lo} <= {carry, alu_res, lo[31:1]}.
- DIV, restoring. Registers: rem=0, quo=req_a, b=req_b. Each iteration:
  - sh = {rem, quo[31]} (33 bits).
  - alu_ct=ALU_SUB, alu_src1=sh[31:0], alu_src2=b.
  - ge = sh[32] | (sh[31:0] >= b).
  - If ge: rem <= alu_res. Otherwise rem <= sh[31:0].
  - quo <= {quo[30:0], ge}.
- Iteration count: cnt counts 0..31. After the iteration at cnt==31, go to DONE.
- Latency: resp_valid rises exactly 32 cycles after the acceptance edge for MUL and for non-zero DIVU.
- DONE:
  - resp_valid=1, req_ready=0.
  - resp_lo/resp_hi/resp_divz are stable and held until resp_ready=1.
  - On resp_valid & resp_ready, go to IDLE and clear resp_valid. resp_lo, resp_hi and resp_divz keep their values until the next result is written.
- req_ready=0 in MUL, DIV and DONE. req_valid is ignored there; no queuing.
- A new request is accepted no earlier than the cycle after the response handshake. There is no same-cycle turnaround.
- ALU outputs hold ALU_ADD with zero operands in IDLE and DONE.
- All arithmetic is unsigned. Overflow cannot occur: the product is a full 64 bits and remainder < divisor.

Test Plan:
- MUL a=7, b=6 -> resp_valid 32 cycles after accept; resp_hi=0, resp_lo=42, resp_divz=0.
- MUL a=32'hFFFFFFFF, b=32'hFFFFFFFF -> resp_hi=32'hFFFFFFFE, resp_lo=32'h00000001 (exercises carry).
- DIVU a=100, b=7 -> resp_lo=14, resp_hi=2. Then DIVU a=32'hFFFFFFFF, b=32'h80000001 -> resp_lo=1, resp_hi=32'h7FFFFFFE (exercises sh[32]).
- DIVU a=5, b=0 -> resp_valid 1 cycle after accept; resp_lo=32'hFFFFFFFF, resp_hi=5, resp_divz=1.
- MUL 3x5 with resp_ready held 0 for 5 cycles after resp_valid -> outputs stay 15/0 and resp_valid stays high. A req_valid pulse during busy/DONE is not accepted (req_ready=0).
- Assert rst=0 at iteration 10 of a DIVU -> next cycle state IDLE, req_ready=1, resp_valid=0, outputs 0. A following MUL 2x2 returns 4.
